// File: rtl/mem_wb_reg.sv
// mem_wb_reg: MEM/WB pipeline register with synchronous data-memory
// read capture, load extraction and writeback-result selection.
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   *_m                 - memory-stage fields captured on advancing edges
//   dmem_dout           - synchronous dmem read word for the resident load
//   stall_w, flush_w    - hold contents / insert bubble (flush wins)
//   valid_w, reg_write_w, rd_w, result_w, status_w - writeback outputs
//   retired_count       - retired-instruction counter; only present when
//                         MEM_WB_RETIRE_CNT_EN is defined, otherwise 0
module mem_wb_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_m,
    input  logic        reg_write_m,
    input  logic [1:0]  result_src_m,
    input  logic [31:0] alu_result_m,
    input  logic [4:0]  rd_m,
    input  logic [31:0] pc_plus4_m,
    input  logic [31:0] c_reg_data_m,
    input  logic [7:0]  status_m,
    input  logic [2:0]  result_bytes_m,
    input  logic [31:0] dmem_dout,
    input  logic        stall_w,
    input  logic        flush_w,
    output logic        valid_w,
    output logic        reg_write_w,
    output logic [4:0]  rd_w,
    output logic [31:0] result_w,
    output logic [7:0]  status_w,
    output logic [63:0] retired_count
);

    logic        valid_q;
    logic        reg_write_q;
    logic [1:0]  result_src_q;
    logic [31:0] alu_result_q;
    logic [4:0]  rd_q;
    logic [31:0] pc_plus4_q;
    logic [31:0] c_reg_data_q;
    logic [7:0]  status_q;
    logic [2:0]  result_bytes_q;

    logic        held;
    logic [31:0] hold_q;

    logic [31:0] load_raw;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;

    always_ff @(posedge clk) begin
        if (rst || flush_w) begin
            valid_q        <= 1'b0;
            reg_write_q    <= 1'b0;
            result_src_q   <= '0;
            alu_result_q   <= '0;
            rd_q           <= '0;
            pc_plus4_q     <= '0;
            c_reg_data_q   <= '0;
            status_q       <= '0;
            result_bytes_q <= '0;
            held           <= 1'b0;
            hold_q         <= '0;
        end else if (stall_w) begin
            // dmem_dout is only valid in the load's first cycle here;
            // latch it so later stall cycles can ignore the live bus.
            if (valid_q && !held) begin
                held   <= 1'b1;
                hold_q <= dmem_dout;
            end
        end else begin
            valid_q        <= valid_m;
            reg_write_q    <= reg_write_m;
            result_src_q   <= result_src_m;
            alu_result_q   <= alu_result_m;
            rd_q           <= rd_m;
            pc_plus4_q     <= pc_plus4_m;
            c_reg_data_q   <= c_reg_data_m;
            status_q       <= status_m;
            result_bytes_q <= result_bytes_m;
            held           <= 1'b0;
        end
    end

    always_comb begin
        load_raw = held ? hold_q : dmem_dout;

        unique case (alu_result_q[1:0])
            2'd0:    byte_sel = load_raw[7:0];
            2'd1:    byte_sel = load_raw[15:8];
            2'd2:    byte_sel = load_raw[23:16];
            default: byte_sel = load_raw[31:24];
        endcase

        // Misaligned halfword offsets are treated as aligned.
        half_sel = alu_result_q[1] ? load_raw[31:16] : load_raw[15:0];

        case (result_bytes_q)
            3'b001:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b101:  load_data = {24'd0, byte_sel};
            3'b010:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b110:  load_data = {16'd0, half_sel};
            default: load_data = load_raw;
        endcase
    end

    always_comb begin
        result_w = '0;
        if (valid_q) begin
            unique case (result_src_q)
                2'b00:   result_w = alu_result_q;
                2'b01:   result_w = load_data;
                2'b10:   result_w = pc_plus4_q;
                default: result_w = c_reg_data_q;
            endcase
        end
    end

    assign valid_w     = valid_q;
    assign reg_write_w = reg_write_q & valid_q;
    assign rd_w        = rd_q;
    assign status_w    = status_q;

`ifdef MEM_WB_RETIRE_CNT_EN
    logic [63:0] retire_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            retire_cnt <= '0;
        end else if (valid_q && !stall_w && !flush_w) begin
            retire_cnt <= retire_cnt + 64'd1;
        end
    end

    assign retired_count = retire_cnt;
`else
    assign retired_count = '0;
`endif

endmodule

// File: tb/tb_mem_wb_reg.sv
// tb_mem_wb_reg: scoreboard bench for mem_wb_reg.
// Directed scenarios followed by randomized stimulus against a record model.
module tb_mem_wb_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_m, reg_write_m;
    logic [1:0]  result_src_m;
    logic [31:0] alu_result_m, pc_plus4_m, c_reg_data_m, dmem_dout;
    logic [4:0]  rd_m;
    logic [7:0]  status_m;
    logic [2:0]  result_bytes_m;
    logic        stall_w, flush_w;
    logic        valid_w, reg_write_w;
    logic [4:0]  rd_w;
    logic [31:0] result_w;
    logic [7:0]  status_w;
    logic [63:0] retired_count;

    mem_wb_reg dut (
        .clk(clk), .rst(rst),
        .valid_m(valid_m), .reg_write_m(reg_write_m),
        .result_src_m(result_src_m), .alu_result_m(alu_result_m),
        .rd_m(rd_m), .pc_plus4_m(pc_plus4_m),
        .c_reg_data_m(c_reg_data_m), .status_m(status_m),
        .result_bytes_m(result_bytes_m), .dmem_dout(dmem_dout),
        .stall_w(stall_w), .flush_w(flush_w),
        .valid_w(valid_w), .reg_write_w(reg_write_w), .rd_w(rd_w),
        .result_w(result_w), .status_w(status_w),
        .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic        rw;
        logic [1:0]  src;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic [31:0] pc4;
        logic [31:0] csr;
        logic [7:0]  st;
        logic [2:0]  bytes;
    } rec_t;

    typedef struct packed {
        logic        valid;
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] res;
        logic [7:0]  st;
        logic [63:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;

    // Model: the instruction record in the register, the word memory
    // returned for it in its first cycle, and the retire tally.
    rec_t        cur;
    logic [31:0] cur_word;
    logic [63:0] cnt;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp,
                     $time);
        end
    endtask

    function automatic logic [31:0] load_val(input rec_t r,
                                             input logic [31:0] w);
        logic [31:0] b, h;
        int off;
        off = int'(r.alu[1:0]);
        b = (w >> (8 * off)) % 256;
        h = (w >> (16 * (off / 2))) % 65536;
        case (r.bytes)
            3'b001: return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'b101: return b;
            3'b010: return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'b110: return h;
            default: return w;
        endcase
    endfunction

    function automatic exp_t expect_of(input rec_t r, input logic [31:0] w,
                                       input logic [63:0] c);
        exp_t e;
        e.valid = r.valid;
        e.rw    = r.valid & r.rw;
        e.rd    = r.rd;
        e.st    = r.st;
        if (!r.valid)          e.res = 0;
        else if (r.src == 2'd0) e.res = r.alu;
        else if (r.src == 2'd1) e.res = load_val(r, w);
        else if (r.src == 2'd2) e.res = r.pc4;
        else                    e.res = r.csr;
`ifdef MEM_WB_RETIRE_CNT_EN
        e.cnt = c;
`else
        e.cnt = 64'd0;
`endif
        return e;
    endfunction

    function automatic rec_t mk(input logic v, input logic rw,
                                input logic [1:0] src,
                                input logic [31:0] alu,
                                input logic [4:0] rd,
                                input logic [2:0] bytes);
        rec_t r;
        r.valid = v;
        r.rw    = rw;
        r.src   = src;
        r.alu   = alu;
        r.rd    = rd;
        r.pc4   = $urandom;
        r.csr   = $urandom;
        r.st    = 8'($urandom);
        r.bytes = bytes;
        return r;
    endfunction

    task automatic step(input rec_t m, input bit st, input bit fl,
                        input bit rs, input logic [31:0] dm);
        bit fresh;
        valid_m        = m.valid;
        reg_write_m    = m.rw;
        result_src_m   = m.src;
        alu_result_m   = m.alu;
        rd_m           = m.rd;
        pc_plus4_m     = m.pc4;
        c_reg_data_m   = m.csr;
        status_m       = m.st;
        result_bytes_m = m.bytes;
        stall_w        = st;
        flush_w        = fl;
        rst            = rs;
        @(posedge clk);
        #1;
        fresh = 0;
        if (rs) begin
            cur = '0;
            cnt = 0;
        end else if (fl) begin
            cur = '0;
        end else if (!st) begin
            if (cur.valid) cnt = cnt + 64'd1;
            cur   = m;
            fresh = 1;
        end
        dmem_dout = dm;
        if (fresh) cur_word = dm;
        sb.push_back(expect_of(cur, cur_word, cnt));
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("valid_w", 64'(valid_w), 64'(e.valid));
            chk("reg_write_w", 64'(reg_write_w), 64'(e.rw));
            chk("rd_w", 64'(rd_w), 64'(e.rd));
            chk("result_w", 64'(result_w), 64'(e.res));
            chk("status_w", 64'(status_w), 64'(e.st));
            chk("retired_count", retired_count, e.cnt);
        end
    end

    rec_t nop, ins;

    initial begin
        cur = '0; cur_word = 0; cnt = 0;
        nop = '0;
        step(nop, 0, 0, 1, 32'h0);
        step(nop, 0, 0, 1, 32'h0);

        // Plain ALU
        ins = mk(1, 1, 2'b00, 32'h1234_5678, 5'd5, 3'b000);
        step(ins, 0, 0, 0, $urandom);
        @(negedge clk);
        chk("alu_result", 64'(result_w), 64'h1234_5678);
        chk("alu_rd", 64'(rd_w), 64'd5);
        chk("alu_rw", 64'(reg_write_w), 64'd1);

        // Byte loads, signed then unsigned
        ins = mk(1, 1, 2'b01, 32'h103, 5'd6, 3'b001);
        step(ins, 0, 0, 0, 32'h80FF_FF7F);
        @(negedge clk);
        chk("lb_result", 64'(result_w), 64'hFFFF_FF80);
        ins = mk(1, 1, 2'b01, 32'h103, 5'd7, 3'b101);
        step(ins, 0, 0, 0, 32'h80FF_FF7F);
        @(negedge clk);
        chk("lbu_result", 64'(result_w), 64'h0000_0080);

        // Stall hold with changing dmem, then release
        ins = mk(1, 1, 2'b01, 32'h200, 5'd8, 3'b000);
        step(ins, 0, 0, 0, 32'hCAFE_BABE);
        ins = mk(1, 1, 2'b01, 32'h204, 5'd9, 3'b000);
        for (int i = 0; i < 3; i++) begin
            step(ins, 1, 0, 0, 32'hDEAD_BEEF);
            @(negedge clk);
            chk("stall_hold", 64'(result_w), 64'hCAFE_BABE);
        end
        step(ins, 0, 0, 0, 32'h1111_2222);
        @(negedge clk);
        chk("post_stall_load", 64'(result_w), 64'h1111_2222);

        // Flush and stall together while a load is held
        step(ins, 1, 0, 0, 32'h3333_4444);
        step(ins, 1, 1, 0, 32'h5555_6666);
        @(negedge clk);
        chk("flush_valid", 64'(valid_w), 64'd0);
        chk("flush_result", 64'(result_w), 64'd0);
        ins = mk(1, 1, 2'b01, 32'h300, 5'd10, 3'b000);
        step(ins, 0, 0, 0, 32'h7777_8888);
        step(ins, 1, 0, 0, 32'h9999_AAAA);
        @(negedge clk);
        chk("load_after_flush", 64'(result_w), 64'h7777_8888);

        // Reset mid-stall, then first load uses live data
        step(ins, 1, 0, 1, 32'hBBBB_CCCC);
        @(negedge clk);
        chk("rst_result", 64'(result_w), 64'd0);
        chk("rst_count", retired_count, 64'd0);
        ins = mk(1, 1, 2'b01, 32'h400, 5'd11, 3'b000);
        step(ins, 0, 0, 0, 32'hDDDD_EEEE);
        @(negedge clk);
        chk("load_after_rst", 64'(result_w), 64'hDDDD_EEEE);

        // Retire tally: 10 valid, 2 stalls, 1 flush
        step(nop, 0, 0, 1, 32'h0);
        for (int i = 0; i < 10; i++) begin
            ins = mk(1, 1, 2'($urandom), $urandom, 5'($urandom),
                     3'($urandom));
            if (i == 3 || i == 6) step(ins, 1, 0, 0, $urandom);
            step(ins, 0, 0, 0, $urandom);
        end
        step(nop, 0, 0, 0, $urandom);
        step(nop, 0, 1, 0, $urandom);
        @(negedge clk);
`ifdef MEM_WB_RETIRE_CNT_EN
        chk("retire10", retired_count, 64'd10);
        force dut.retire_cnt = 64'hFFFF_FFFF_FFFF_FFFE;
        #1;
        release dut.retire_cnt;
        cnt = 64'hFFFF_FFFF_FFFF_FFFE;
        for (int i = 0; i < 3; i++) begin
            ins = mk(1, 1, 2'b00, $urandom, 5'($urandom), 3'b000);
            step(ins, 0, 0, 0, $urandom);
        end
        @(negedge clk);
        chk("retire_wrap", retired_count, 64'd0);
`else
        chk("retire_tied", retired_count, 64'd0);
`endif

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            ins = mk(($urandom % 5) != 0, 1'($urandom), 2'($urandom),
                     $urandom, 5'($urandom), 3'($urandom));
            step(ins, ($urandom % 3) == 0, ($urandom % 12) == 0,
                 ($urandom % 60) == 0, $urandom);
        end

        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_wb_reg.md
# mem_wb_reg

Pipeline register between the memory-access stage and writeback. It captures the memory stage's control and data fields on each advancing clock edge and supports stall (hold) and flush (bubble). It also owns the synchronous data-memory read path: `dmem_dout` arrives one cycle after the address, in the cycle the load sits in this register. The block holds that word across stalls, extracts the byte, half or word, and presents the final writeback value and register-file write enable.

## Interface
Parameters:
- none

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `valid_m` in 1: memory stage holds a real instruction.
- `reg_write_m` in 1: instruction writes a register.
- `result_src_m` in 2: 00 ALU, 01 load data, 10 pc+4, 11 control-register data.
- `alu_result_m` in 32: ALU result; bits [1:0] are the load byte offset.
- `rd_m` in 5: destination register.
- `pc_plus4_m` in 32: link value.
- `c_reg_data_m` in 32: control/status-register read value.
- `status_m` in 8: status flags forwarded unchanged.
- `result_bytes_m` in 3: load size; 000 lw, 001 lb, 010 lh, 101 lbu, 110 lhu; other codes decode as lw.
- `dmem_dout` in 32: synchronous data-memory read word for the instruction currently in this register.
- `stall_w` in 1: hold contents.
- `flush_w` in 1: insert bubble.
- `valid_w` out 1: registered valid.
- `reg_write_w` out 1: `reg_write_q & valid_w`.
- `rd_w` out 5: registered rd.
- `result_w` out 32: final writeback value.
- `status_w` out 8: registered status.
- `retired_count` out 64: retired-instruction count (see Configuration).

## Operation
- Register update priority: `rst` > `flush_w` > `stall_w` > load.
  - `rst`: all fields zero.
  - `flush_w`: `valid_q`=0 and `reg_write_q`=0; other fields don't-care but are zeroed.
  - `stall_w`: all fields hold.
  - Otherwise: all `*_m` fields load.
- Load-data hold:
  - State bits: `held` (1) and `hold_q` (32).
  - Set `held` and capture `dmem_dout` into `hold_q` when `valid_q & stall_w & !held & !flush_w`.
  - Clear `held` on `rst`, `flush_w`, or any non-stalled edge.
  - Raw load word = `held ? hold_q : dmem_dout`.
- Load extraction, with offset = `alu_result_q[1:0]`:
  - lb/lbu: select byte offset; sign-extend for lb, zero-extend for lbu.
  - lh/lhu: select halfword at `offset[1]`; `offset[0]` is ignored and treated as aligned.
  - lw: the word.
- `result_w` mux on `result_src_q` (combinational from registered state). When `valid_w`=0, `result_w` is 0.
- Reset values of all outputs are 0: `valid_w`, `reg_write_w`, `rd_w`, `result_w`, `status_w`, `retired_count`.

## Timing
- Latency: inputs visible on outputs one cycle after an advancing edge.
- `dmem_dout` is sampled only in the cycle after the load entered this register, or from `hold_q` thereafter. Any change on `dmem_dout` during a stall must not alter `result_w`.
- `flush_w` and `stall_w` together: flush wins and `held` clears.
- Stall with `valid_q`=0: nothing is captured and `held` stays 0.
- `rst` asserted mid-stall: next cycle all outputs are 0 and `held`=0.
- No combinational path from `stall_w`/`flush_w` to any output.

## Configuration
- Macro `MEM_WB_RETIRE_CNT_EN`.
- Defined:
  - 64-bit counter increments on each edge where `valid_q & !stall_w & !flush_w & !rst`.
  - Wraps from all-ones to 0.
  - Reset to 0.
  - Drives `retired_count`.
- Undefined: no counter logic; `retired_count` tied to 0.

## Test plan
- Plain ALU: `valid_m`=1, `reg_write_m`=1, `result_src_m`=00, `alu_result_m`=0x1234_5678, `rd_m`=5, one edge -> `result_w`=0x1234_5678, `rd_w`=5, `reg_write_w`=1.
- Byte loads: `alu_result_m`=0x103, `result_bytes_m`=001, `dmem_dout`=0x80FF_FF7F next cycle -> `result_w`=0xFFFF_FF80. Repeat with 101 -> `result_w`=0x0000_0080.
- Stall hold: lw in register, `dmem_dout`=0xCAFEBABE, then `stall_w`=1 for 3 cycles while `dmem_dout` changes to 0xDEADBEEF -> `result_w` stays 0xCAFEBABE. Release -> next instruction loads.
- Flush priority: `stall_w`=1 and `flush_w`=1 on the same edge -> `valid_w`=0, `reg_write_w`=0, `result_w`=0, `held` cleared.
- Reset mid-stall: `rst`=1 during a held load -> all outputs 0 next cycle. The first load after reset uses live `dmem_dout`.
- With `MEM_WB_RETIRE_CNT_EN`: 10 valid instructions, 2 stalled cycles, 1 flushed cycle -> `retired_count`=10. Preload the counter near all-ones via a forced value and check wrap to 0.
